// File: rtl/mul_arbiter_pkg.sv
// Shared types and constants for the two-lane multiplier arbiter.
// Bus packing helpers keep the interface and the top agreeing on widths.
package mul_arbiter_pkg;

    localparam int MA_XLEN    = 32;
    localparam int MA_MUL_LAT = 2;

    typedef enum logic [1:0] {
        MA_IDLE = 2'd0,
        MA_BUSY = 2'd1,
        MA_DONE = 2'd2
    } ma_state_e;

    // {use_mul, use_high, is_unsigned, x, y}
    function automatic int es_bus_w(input int xlen);
        return 2 * xlen + 3;
    endfunction

    // {result, ok}
    function automatic int mul_bus_w(input int xlen);
        return xlen + 1;
    endfunction

endpackage

// File: rtl/mul_arbiter_if.sv
// Lane request/response buses plus the shared multiplier port.
// slave = arbiter side, master = lanes and multiplier side.
interface mul_arbiter_if import mul_arbiter_pkg::*; #(
    parameter int XLEN = MA_XLEN
) ();

    logic [es_bus_w(XLEN)-1:0]  es_to_mul_bus0;
    logic [es_bus_w(XLEN)-1:0]  es_to_mul_bus1;
    logic [mul_bus_w(XLEN)-1:0] mul_to_es_bus0;
    logic [mul_bus_w(XLEN)-1:0] mul_to_es_bus1;
    logic [XLEN-1:0]            mul_x;
    logic [XLEN-1:0]            mul_y;
    logic                       mul_signed;
    logic                       mul_use_high;
    logic                       mul_en;
    logic [XLEN-1:0]            mul_result;
    logic                       mul_busy;

    modport slave (
        input  es_to_mul_bus0,
        input  es_to_mul_bus1,
        input  mul_result,
        output mul_to_es_bus0,
        output mul_to_es_bus1,
        output mul_x,
        output mul_y,
        output mul_signed,
        output mul_use_high,
        output mul_en,
        output mul_busy
    );

    modport master (
        output es_to_mul_bus0,
        output es_to_mul_bus1,
        output mul_result,
        input  mul_to_es_bus0,
        input  mul_to_es_bus1,
        input  mul_x,
        input  mul_y,
        input  mul_signed,
        input  mul_use_high,
        input  mul_en,
        input  mul_busy
    );

endinterface

// File: rtl/mul_arbiter_rr_pick.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// lane that was not granted last.
module mul_arbiter_rr_pick (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    assign gnt_valid = |req;
    assign gnt_idx   = (&req) ? ~last_grant : req[1];

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin sharing of one pipelined multiplier between two execute lanes.
// Operands are registered on grant; the product half returns as a one-cycle ok.
//
//   state   | meaning
//   IDLE    | waiting for a request; picks a lane round-robin
//   BUSY    | multiplier enabled, counting MUL_LAT cycles, owner may withdraw
//   DONE    | ok pulse with the captured result on the owner's bus
module mul_arbiter import mul_arbiter_pkg::*; #(
    parameter int XLEN    = MA_XLEN,
    parameter int MUL_LAT = MA_MUL_LAT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    mul_arbiter_if.slave bus
);

    localparam int               CNT_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);
    localparam int               USE_B    = 2 * XLEN + 2;
    localparam int               HIGH_B   = 2 * XLEN + 1;
    localparam int               UNS_B    = 2 * XLEN;

    ma_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             owner_q;
    logic             last_grant_q;
    logic [XLEN-1:0]  x_q;
    logic [XLEN-1:0]  y_q;
    logic [XLEN-1:0]  result_q;
    logic             signed_q;
    logic             use_high_q;
    logic             mul_en_q;
    logic             busy_q;
    logic             done_q;

    logic [1:0]        req;
    logic              gnt_valid;
    logic              gnt_idx;
    logic [2*XLEN+1:0] gnt_bus;
    logic              owner_req;
    logic              ok;

    assign req       = {bus.es_to_mul_bus1[USE_B], bus.es_to_mul_bus0[USE_B]};
    assign gnt_bus   = gnt_idx ? bus.es_to_mul_bus1[2*XLEN+1:0]
                               : bus.es_to_mul_bus0[2*XLEN+1:0];
    assign owner_req = owner_q ? req[1] : req[0];

    mul_arbiter_rr_pick u_pick (
        .req        (req),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= MA_IDLE;
            cnt_q        <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            x_q          <= '0;
            y_q          <= '0;
            result_q     <= '0;
            signed_q     <= 1'b0;
            use_high_q   <= 1'b0;
            mul_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else if (flush) begin
            // Flush drops the operation but keeps round-robin history.
            state_q  <= MA_IDLE;
            cnt_q    <= '0;
            mul_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                MA_IDLE: begin
                    if (gnt_valid) begin
                        x_q          <= gnt_bus[2*XLEN-1:XLEN];
                        y_q          <= gnt_bus[XLEN-1:0];
                        use_high_q   <= gnt_bus[HIGH_B];
                        signed_q     <= ~gnt_bus[UNS_B];
                        owner_q      <= gnt_idx;
                        last_grant_q <= gnt_idx;
                        cnt_q        <= '0;
                        state_q      <= MA_BUSY;
                        mul_en_q     <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                MA_BUSY: begin
                    if (!owner_req) begin
                        state_q  <= MA_IDLE;
                        cnt_q    <= '0;
                        mul_en_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        result_q <= bus.mul_result;
                        state_q  <= MA_DONE;
                        cnt_q    <= '0;
                        mul_en_q <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                MA_DONE: begin
                    state_q <= MA_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q  <= MA_IDLE;
                    cnt_q    <= '0;
                    mul_en_q <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

    // A flush landing on the DONE cycle must still suppress the ok pulse.
    assign ok = done_q & ~flush & ~reset;

    assign bus.mul_to_es_bus0 = (ok && !owner_q) ? {result_q, 1'b1} : '0;
    assign bus.mul_to_es_bus1 = (ok &&  owner_q) ? {result_q, 1'b1} : '0;
    assign bus.mul_x          = x_q;
    assign bus.mul_y          = y_q;
    assign bus.mul_signed     = signed_q;
    assign bus.mul_use_high   = use_high_q;
    assign bus.mul_en         = mul_en_q;
    assign bus.mul_busy       = busy_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter: stimulus pushes expected ok responses,
// a negedge monitor pops and compares them and checks idle buses stay zero.
module tb_mul_arbiter;
    import mul_arbiter_pkg::*;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    int   cyc = 0;

    mul_arbiter_if #(.XLEN(XLEN)) bus ();

    mul_arbiter #(.XLEN(XLEN), .MUL_LAT(2)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One-register multiplier: product of cycle-N operands visible in cycle N+1.
    function automatic logic [XLEN-1:0] mul_model(input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                                                 input logic sgn, input logic hi);
        logic [2*XLEN-1:0] xe, ye, p;
        xe = sgn ? {{XLEN{x[XLEN-1]}}, x} : {{XLEN{1'b0}}, x};
        ye = sgn ? {{XLEN{y[XLEN-1]}}, y} : {{XLEN{1'b0}}, y};
        p  = xe * ye;
        return hi ? p[2*XLEN-1:XLEN] : p[XLEN-1:0];
    endfunction

    always @(posedge clk) begin
        if (reset)
            bus.mul_result <= '0;
        else if (bus.mul_en)
            bus.mul_result <= mul_model(bus.mul_x, bus.mul_y, bus.mul_signed, bus.mul_use_high);
    end

    typedef struct {
        bit              lane;
        logic [XLEN-1:0] res;
        int              cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;

    task automatic check(input string name, input logic [XLEN:0] act, input logic [XLEN:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic mon_lane(input int l, input logic [XLEN:0] b);
        exp_t e;
        bit   lb;
        lb = (l != 0);
        if (b[0]) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ok: lane %0d result %h at cycle %0d, required no ok", l, b[XLEN:1], cyc);
            end else begin
                e = sb_q.pop_front();
                if (e.lane != lb || e.res !== b[XLEN:1] || e.cyc != cyc) begin
                    n_fail++;
                    $display("FAIL ok_resp: lane %0d result %h cycle %0d, required lane %0d result %h cycle %0d",
                             l, b[XLEN:1], cyc, e.lane, e.res, e.cyc);
                end
            end
        end else begin
            check(l == 0 ? "bus0_idle_zero" : "bus1_idle_zero", b, '0);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            mon_lane(0, bus.mul_to_es_bus0);
            mon_lane(1, bus.mul_to_es_bus1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int lane, input bit hi, input bit uns,
                           input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
        logic [2*XLEN+2:0] v;
        v = {1'b1, hi, uns, x, y};
        if (lane == 0) bus.es_to_mul_bus0 = v;
        else           bus.es_to_mul_bus1 = v;
    endtask

    task automatic clr_req(input int lane);
        if (lane == 0) bus.es_to_mul_bus0 = '0;
        else           bus.es_to_mul_bus1 = '0;
    endtask

    task automatic expect_ok(input int lane, input logic [XLEN-1:0] r, input int c);
        exp_t e;
        e.lane = (lane != 0);
        e.res  = r;
        e.cyc  = c;
        sb_q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bus0"}, bus.mul_to_es_bus0, '0);
        check({tag, "_bus1"}, bus.mul_to_es_bus1, '0);
        check({tag, "_mul_x"}, {1'b0, bus.mul_x}, '0);
        check({tag, "_mul_y"}, {1'b0, bus.mul_y}, '0);
        check({tag, "_signed"}, {32'd0, bus.mul_signed}, '0);
        check({tag, "_use_high"}, {32'd0, bus.mul_use_high}, '0);
        check({tag, "_mul_en"}, {32'd0, bus.mul_en}, '0);
        check({tag, "_busy"}, {32'd0, bus.mul_busy}, '0);
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        bus.es_to_mul_bus0 = '0;
        bus.es_to_mul_bus1 = '0;
        tick(2);
        check_all_zero("reset");
        reset  = 1'b0;
        mon_en = 1'b1;
        tick(1);

        // Lane 0 signed -2 * 3, low half
        set_req(0, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'd3);
        expect_ok(0, 32'hFFFF_FFFA, cyc + 3);
        tick(1);
        check("t1_en_c1", {32'd0, bus.mul_en}, 33'd1);
        check("t1_busy_c1", {32'd0, bus.mul_busy}, 33'd1);
        tick(1);
        check("t1_en_c2", {32'd0, bus.mul_en}, 33'd1);
        tick(1);
        check("t1_en_c3", {32'd0, bus.mul_en}, 33'd0);
        clr_req(0);
        tick(1);
        check("t1_x_hold", {1'b0, bus.mul_x}, {1'b0, 32'hFFFF_FFFE});
        check("t1_signed_hold", {32'd0, bus.mul_signed}, 33'd1);

        // Lane 1 unsigned then signed 0x80000000 * 4, high half
        set_req(1, 1'b1, 1'b1, 32'h8000_0000, 32'd4);
        expect_ok(1, 32'h0000_0002, cyc + 3);
        tick(1);
        check("t2u_signed", {32'd0, bus.mul_signed}, 33'd0);
        check("t2u_use_high", {32'd0, bus.mul_use_high}, 33'd1);
        tick(2);
        clr_req(1);
        tick(1);
        set_req(1, 1'b1, 1'b0, 32'h8000_0000, 32'd4);
        expect_ok(1, 32'hFFFF_FFFE, cyc + 3);
        tick(3);
        clr_req(1);
        tick(1);

        // Both lanes held continuously after reset: 0, 1, 0
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        set_req(0, 1'b0, 1'b0, 32'd5, 32'd7);
        set_req(1, 1'b0, 1'b1, 32'd6, 32'd9);
        expect_ok(0, 32'd35, cyc + 3);
        expect_ok(1, 32'd54, cyc + 7);
        expect_ok(0, 32'd35, cyc + 11);
        tick(11);
        clr_req(0);
        clr_req(1);
        tick(1);

        // Flush in the capture cycle, then a lane 1 request right after
        set_req(0, 1'b0, 1'b1, 32'd100, 32'd100);
        tick(2);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("t4_busy_after_flush", {32'd0, bus.mul_busy}, 33'd0);
        clr_req(0);
        set_req(1, 1'b0, 1'b1, 32'd3, 32'd4);
        expect_ok(1, 32'd12, cyc + 3);
        tick(3);
        clr_req(1);
        tick(1);

        // Flush coincident with DONE
        set_req(0, 1'b0, 1'b1, 32'd7, 32'd7);
        tick(3);
        flush = 1'b1;
        clr_req(0);
        #1;
        check("t5_no_ok_on_flush", bus.mul_to_es_bus0, '0);
        tick(1);
        flush = 1'b0;
        tick(1);

        // Owner withdraws in cycle 1
        set_req(0, 1'b0, 1'b1, 32'd9, 32'd9);
        tick(1);
        clr_req(0);
        tick(1);
        check("t6_idle_after_withdraw", {32'd0, bus.mul_busy}, 33'd0);
        tick(3);

        // Reset in BUSY (last grant was lane 0); after reset lane 0 wins the tie
        set_req(0, 1'b0, 1'b1, 32'd8, 32'd8);
        tick(1);
        reset = 1'b1;
        tick(1);
        check_all_zero("t7_reset_busy");
        reset = 1'b0;
        set_req(0, 1'b0, 1'b1, 32'd10, 32'd10);
        set_req(1, 1'b0, 1'b1, 32'd2, 32'd2);
        expect_ok(0, 32'h0000_0064, cyc + 3);
        tick(3);
        clr_req(0);
        clr_req(1);
        tick(1);

        for (int i = 0; i < 50 && sb_q.size() != 0; i++) tick(1);
        check("scoreboard_drained", 33'(sb_q.size()), 33'd0);
        tick(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Shares the single pipelined 32x32 multiplier between the two execute pipes (lane 0 and lane 1).
- Grants one requester at a time using round-robin priority, and registers that requester's operands.
- Sequences the multiplier for a fixed latency, then returns the selected half of the product to the owning lane as a one-cycle ok pulse.
- Replaces fixed lane-0 priority. Handles global flush and owner withdrawal mid-operation.

Parameters:
- MUL_LAT, 2: multiplier pipeline depth in cycles, from operands stable to product valid; legal range ≥1.
- XLEN, 32: operand/result width.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- flush, input, 1: global pipeline flush; kills any in-flight operation.
- es_to_mul_bus0, input, XLEN*2+3: lane 0 request {use_mul, use_high, is_unsigned, x, y}; use_mul is the request valid.
- es_to_mul_bus1, input, XLEN*2+3: lane 1 request, same packing.
- mul_to_es_bus0, output, XLEN+1: {result, ok} to lane 0.
- mul_to_es_bus1, output, XLEN+1: {result, ok} to lane 1.
- mul_x, output, XLEN: operand x to multiplier.
- mul_y, output, XLEN: operand y to multiplier.
- mul_signed, output, 1: ~is_unsigned of the granted request.
- mul_use_high, output, 1: select product bits [2*XLEN-1:XLEN].
- mul_en, output, 1: multiplier enable.
- mul_result, input, XLEN: multiplier result (half already selected by mul_use_high).
- mul_busy, output, 1: high while state is not IDLE.

Behaviour:
- Clocking: all state changes on posedge clk. Reset is synchronous and active-high.
- Reset values: state=IDLE, cnt=0, owner=0, last_grant=1 (lane 0 wins first tie), operand registers=0, result register=0. All outputs 0.
- Requester contract: a lane holds use_mul and its operands stable until it sees ok=1. It may drop use_mul at any time to withdraw.
- States:
  - IDLE: if no use_mul, stay.
    - If exactly one lane requests, grant it.
    - If both request, grant ~last_grant.
    - On grant: latch x, y, use_high, is_unsigned; set owner and last_grant=owner; cnt=0; go BUSY.
  - BUSY: mul_en=1; the multiplier is driven from the operand registers; cnt increments each cycle.
    - When cnt==MUL_LAT-1: capture mul_result into the result register and go DONE.
  - DONE: ok=1 and result=result register on the owner's bus for exactly one cycle; mul_en=0; next state IDLE.
- Latency: request first seen in IDLE at cycle 0; ok asserted in cycle MUL_LAT+1 (3 with default MUL_LAT). Earliest next grant is cycle MUL_LAT+2.
- Response routing: the non-owner bus always outputs {result=0, ok=0}. The owner bus shows result=0 when ok=0.
- Flush: if flush=1 in any state, next state is IDLE and cnt=0. No ok is issued, including when flush coincides with the DONE cycle or the capture cycle. last_grant is unchanged. A request present during flush in IDLE is not granted.
- Withdrawal: if the owner's use_mul=0 during BUSY, the operation aborts to IDLE next cycle with no ok. The non-owner's use_mul has no effect until IDLE.
- Outputs while not BUSY: mul_x, mul_y, mul_signed and mul_use_high hold the registered values; mul_en=0.
- Reset mid-operation: same as flush; all registers return to reset values.
- Starvation bound: a lane held valid is granted within one foreign operation.

Decomposition:
- Shared header (define.vh, existing): ES_TO_MUL_BUS_MD, MUL_TO_ES_BUS_MD widths; state encodings MA_IDLE=2'd0, MA_BUSY=2'd1, MA_DONE=2'd2.
- One natural sub-module, mul_rr_pick: a combinational 2-way round-robin picker taking req[1:0] and last_grant, producing gnt_valid and gnt_idx.
- The multiplier instance stays outside; MUL_top wraps both blocks.

Test Plan:
- Reset, then lane 0 requests signed x=0xFFFFFFFE, y=3, use_high=0 at cycle 0 → mul_en high in cycles 1–2; mul_to_es_bus0={0xFFFFFFFA,1} in cycle 3 only; bus1 stays 0.
- Lane 1 requests unsigned x=0x80000000, y=4, use_high=1 → lane 1 ok in cycle 3 with result 0x00000002; a signed request with the same operands returns 0xFFFFFFFE.
- Both lanes held valid continuously after reset → grants alternate lane0, lane1, lane0; ok pulses every 4 cycles in cycles 3, 7, 11, on alternating buses.
- Flush asserted in cycle 2 of a lane-0 operation → no ok ever; mul_busy=0 in cycle 3; a new lane-1 request in cycle 3 gives ok in cycle 6.
- Flush coincident with the DONE cycle → ok stays 0. Owner drops use_mul in cycle 1 → abort, IDLE in cycle 2, no ok.
- Reset asserted in BUSY → next cycle all outputs 0, state IDLE, and lane 0 wins the next tie.
